ssm4_decrypt_core: RTL and testbench

- Iterative SM4 block decryption engine: 128-bit ciphertext plus 128-bit key in, 128-bit plaintext out, one round per clock.
- Round keys are expanded forward, stored locally, then consumed in reverse order (rk31 down to rk0).
- The optional encrypt mode uses the same datapath with forward key order.
- Uses four instances of the team's existing sm4_sbox (one per byte lane), shared between key expansion and rounds.
- Sits behind the SM4 instruction/accelerator front end as the inverse-direction counterpart of the forward SM4 path.

---
 rtl/ssm4_decrypt_core.sv | 218 +++++++++++++++++++++
 tb/tb_ssm4_decrypt_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ssm4_decrypt_core.sv
// Iterative SM4 block cipher core: one round per clock, round keys expanded
// forward into a local register file and consumed in reverse for decryption.

module sm4_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign out_o = SBOX[in_i];

endmodule

module ssm4_decrypt_core #(
    parameter int ENCRYPT_EN = 0,
    parameter int KEY_CACHE  = 1
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    input  logic         in_key_new,
    input  logic         in_enc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [31:0] l_round(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    // CK byte j of word i is ((4i+j)*7) mod 256; the 8-bit product truncates naturally.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] w;
        logic [7:0]  base;
        base = {1'b0, i, 2'b00};
        w    = 32'd0;
        for (int j = 0; j < 4; j++) begin
            w[31-8*j -: 8] = (base + 8'(j)) * 8'd7;
        end
        return w;
    endfunction

    state_t        state_q;
    logic [4:0]    cnt_q;
    logic          rk_valid_q;
    logic          enc_q;
    logic [127:0]  x_q;
    logic [127:0]  k_q;
    logic [127:0]  out_data_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [31:0]   rk_mem_q [32];

    logic [4:0]    rk_idx_s;
    logic [31:0]   rk_rd_s;
    logic [31:0]   sbox_in_s;
    logic [31:0]   tau_s;
    logic [31:0]   x_next_s;
    logic [31:0]   k_next_s;
    logic          need_exp_s;
    logic          enc_in_s;

    // Four byte-lane S-boxes shared by key expansion and the cipher rounds.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .in_i  (sbox_in_s[8*g +: 8]),
            .out_o (tau_s[8*g +: 8])
        );
    end

    // Round-key selection, S-box input multiplexing and next-word computation.
    always_comb begin
        rk_idx_s   = 5'd0;
        sbox_in_s  = 32'd0;
        x_next_s   = 32'd0;
        k_next_s   = 32'd0;
        need_exp_s = 1'b0;
        enc_in_s   = 1'b0;

        if (enc_q) begin
            rk_idx_s = cnt_q;
        end else begin
            rk_idx_s = 5'd31 - cnt_q;
        end
        rk_rd_s = rk_mem_q[rk_idx_s];

        if (state_q == ST_KEYEXP) begin
            sbox_in_s = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck_word(cnt_q);
        end else begin
            sbox_in_s = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_rd_s;
        end

        k_next_s   = k_q[127:96] ^ l_key(tau_s);
        x_next_s   = x_q[127:96] ^ l_round(tau_s);
        need_exp_s = in_key_new | (KEY_CACHE == 0) | ~rk_valid_q;
        enc_in_s   = (ENCRYPT_EN != 0) & in_enc;
    end

    // Round-key register file; contents are only meaningful while rk_valid_q is set.
    always_ff @(posedge g_clk) begin
        if (state_q == ST_KEYEXP) begin
            rk_mem_q[cnt_q] <= k_next_s;
        end
    end

    // Control FSM with registered handshake outputs and the data/key windows.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            rk_valid_q  <= 1'b0;
            enc_q       <= 1'b0;
            x_q         <= 128'd0;
            k_q         <= 128'd0;
            out_data_q  <= 128'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= in_data;
                        enc_q      <= enc_in_s;
                        cnt_q      <= 5'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (need_exp_s) begin
                            // Stored keys are about to be overwritten, so they stop being valid now.
                            k_q        <= in_key ^ FK;
                            rk_valid_q <= 1'b0;
                            state_q    <= ST_KEYEXP;
                        end else begin
                            state_q    <= ST_ROUND;
                        end
                    end
                end
                ST_KEYEXP: begin
                    k_q   <= {k_q[95:0], k_next_s};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        rk_valid_q <= 1'b1;
                        state_q    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    x_q   <= {x_q[95:0], x_next_s};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        // Final reverse substitution: {X35, X34, X33, X32}.
                        out_data_q  <= {x_next_s, x_q[31:0], x_q[63:32], x_q[95:64]};
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= 5'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ssm4_decrypt_core.sv
// Directed bench for ssm4_decrypt_core: a decrypt-only cached build and an
// encrypt-capable uncached build, checked against the SM4 standard vector.

module tb_ssm4_decrypt_core;

    localparam logic [127:0] KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] PT  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT  = 128'h681EDF34D206965E86B3E94F536E4246;

    logic         g_clk;
    logic         rst_n      [2];
    logic         in_valid   [2];
    logic         in_ready   [2];
    logic [127:0] in_data    [2];
    logic [127:0] in_key     [2];
    logic         in_key_new [2];
    logic         in_enc     [2];
    logic         out_valid  [2];
    logic         out_ready  [2];
    logic [127:0] out_data   [2];
    logic         busy       [2];

    int n_vec;
    int n_miss;

    typedef struct {
        int           dut;
        logic [127:0] data;
        logic [127:0] key;
        logic         kn;
        logic         en;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vt [5];

    ssm4_decrypt_core #(.ENCRYPT_EN(0), .KEY_CACHE(1)) u_dec (
        .g_clk(g_clk), .g_resetn(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_key(in_key[0]), .in_key_new(in_key_new[0]), .in_enc(in_enc[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    ssm4_decrypt_core #(.ENCRYPT_EN(1), .KEY_CACHE(0)) u_enc (
        .g_clk(g_clk), .g_resetn(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_key(in_key[1]), .in_key_new(in_key_new[1]), .in_enc(in_enc[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // in_ready must track IDLE exactly, i.e. be the complement of busy.
    always @(negedge g_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] === 1'b1 && in_ready[d] !== !busy[d]) begin
                n_miss++;
                $display("FAIL ready_vs_busy dut%0d: in_ready=%b busy=%b", d, in_ready[d], busy[d]);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(input int d, input logic [127:0] data, input logic [127:0] key,
                             input logic kn, input logic en);
        int guard;
        guard = 0;
        @(negedge g_clk);
        while (!in_ready[d] && guard < 300) begin
            @(negedge g_clk);
            guard++;
        end
        if (!in_ready[d]) begin
            n_vec++;
            n_miss++;
            $display("FAIL in_ready_timeout dut%0d: got 0 expected 1", d);
        end
        in_valid[d] = 1'b1; in_data[d] = data; in_key[d] = key;
        in_key_new[d] = kn; in_enc[d] = en;
        @(posedge g_clk);
        #1;
        in_valid[d]   = 1'b0;
        in_data[d]    = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key[d]     = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key_new[d] = 1'($urandom_range(0, 1));
        in_enc[d]     = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(input int d, input logic [127:0] data, input logic [127:0] key,
                          input logic kn, input logic en, input int hold,
                          output logic [127:0] res, output int lat,
                          output logic bp_ok, output logic rdy_after);
        start_req(d, data, key, kn, en);
        lat = 0;
        do begin
            @(negedge g_clk);
            lat++;
        end while (!out_valid[d] && lat < 300);
        res   = out_data[d];
        bp_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge g_clk);
            if (!out_valid[d] || out_data[d] !== res || in_ready[d]) bp_ok = 1'b0;
        end
        out_ready[d] = 1'b1;
        @(posedge g_clk);
        #1;
        out_ready[d] = 1'b0;
        rdy_after = in_ready[d];
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] rk;
        logic [127:0] rp;
        logic [127:0] ct;
        int           lat;
        logic         bp_ok;
        logic         rdy;
        logic         seen;

        n_vec = 0;
        n_miss = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 128'd0; in_key[d] = 128'd0;
            in_key_new[d] = 1'b0; in_enc[d] = 1'b0; out_ready[d] = 1'b0;
        end

        vt[0] = '{0, CT, KEY, 1'b1, 1'b0, PT, 65};
        vt[1] = '{0, CT, KEY, 1'b0, 1'b0, PT, 33};
        vt[2] = '{0, CT, KEY, 1'b0, 1'b1, PT, 33};
        vt[3] = '{1, PT, KEY, 1'b0, 1'b1, CT, 65};
        vt[4] = '{1, CT, KEY, 1'b0, 1'b0, PT, 65};

        repeat (3) @(negedge g_clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_in_ready%0d", d), 128'(in_ready[d]), 128'd1);
            chk($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'd0);
            chk($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'd0);
            chk($sformatf("rst_out_data%0d", d), out_data[d], 128'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_req(vt[i].dut, vt[i].data, vt[i].key, vt[i].kn, vt[i].en, 0, res, lat, bp_ok, rdy);
            chk($sformatf("vec%0d_data", i), res, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vt[i].lat));
        end

        // Backpressure: result held for 20 cycles with out_ready low.
        do_req(0, CT, KEY, 1'b0, 1'b0, 20, res, lat, bp_ok, rdy);
        chk("bp_data", res, PT);
        chk("bp_hold_stable", 128'(bp_ok), 128'd1);
        chk("bp_ready_after_release", 128'(rdy), 128'd1);

        // Reset mid-ROUND of a cached request, then in_key_new=0 must re-expand.
        start_req(0, CT, KEY, 1'b0, 1'b0);
        repeat (20) @(negedge g_clk);
        rst_n[0] = 1'b0;
        @(negedge g_clk);
        chk("abort_busy", 128'(busy[0]), 128'd0);
        chk("abort_in_ready", 128'(in_ready[0]), 128'd1);
        rst_n[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge g_clk);
            if (out_valid[0]) seen = 1'b1;
        end
        chk("abort_no_out_valid", 128'(seen), 128'd0);
        do_req(0, CT, KEY, 1'b0, 1'b0, 0, res, lat, bp_ok, rdy);
        chk("abort_round_data", res, PT);
        chk("abort_round_latency", 128'(lat), 128'd65);

        // Reset mid-KEYEXP of a new-key request leaves the key store invalid.
        start_req(0, CT, KEY, 1'b1, 1'b0);
        repeat (10) @(negedge g_clk);
        rst_n[0] = 1'b0;
        @(negedge g_clk);
        rst_n[0] = 1'b1;
        do_req(0, CT, KEY, 1'b0, 1'b0, 0, res, lat, bp_ok, rdy);
        chk("abort_keyexp_data", res, PT);
        chk("abort_keyexp_latency", 128'(lat), 128'd65);

        // Random round trips: encrypt on the forward build, decrypt on the inverse build.
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            repeat ($urandom_range(0, 3)) @(negedge g_clk);
            do_req(1, rp, rk, 1'b1, 1'b1, $urandom_range(0, 5), ct, lat, bp_ok, rdy);
            repeat ($urandom_range(0, 3)) @(negedge g_clk);
            do_req(0, ct, rk, 1'b1, 1'b0, $urandom_range(0, 5), res, lat, bp_ok, rdy);
            chk($sformatf("rand%0d_newkey", i), res, rp);
            do_req(0, ct, rk, 1'b0, 1'b0, $urandom_range(0, 5), res, lat, bp_ok, rdy);
            chk($sformatf("rand%0d_cached", i), res, rp);
            chk($sformatf("rand%0d_cached_latency", i), 128'(lat), 128'd33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
